// File: rtl/yavne_mmio_pkg.sv
// yavne_mmio_pkg: shared MMIO widths, VGA window defaults and the packed write-buffer entry.
package yavne_mmio_pkg;
  localparam int MMIO_ADDR_W = 16;
  localparam int MMIO_DATA_W = 8;
  localparam int MMIO_ENTRY_W = MMIO_ADDR_W + MMIO_DATA_W;
  localparam logic [MMIO_ADDR_W-1:0] VGA_WIN_BASE = 16'h0200;
  localparam logic [MMIO_ADDR_W-1:0] VGA_WIN_LAST = 16'h05FF;
  typedef struct packed {
    logic [MMIO_ADDR_W-1:0] addr;
    logic [MMIO_DATA_W-1:0] data;
  } entry_t;
  function automatic logic in_window(input logic [MMIO_ADDR_W-1:0] a, base, last);
    return a >= base && a <= last;
  endfunction
endpackage

// File: rtl/mmio_write_buffer_if.sv
// mmio_write_buffer_if: CPU write bus plus the drained {addr,data} handshake toward the VGA port.
interface mmio_write_buffer_if;
  import yavne_mmio_pkg::*;
  logic cpu_we;
  logic [MMIO_ADDR_W-1:0] cpu_addr;
  logic [MMIO_DATA_W-1:0] cpu_data;
  logic out_valid;
  logic out_ready;
  logic [MMIO_ADDR_W-1:0] out_addr;
  logic [MMIO_DATA_W-1:0] out_data;
  modport master (output cpu_we, cpu_addr, cpu_data, out_ready, input out_valid, out_addr, out_data);
  modport slave (input cpu_we, cpu_addr, cpu_data, out_ready, output out_valid, out_addr, out_data);
endinterface

// File: rtl/mmio_wbuf_fifo.sv
// mmio_wbuf_fifo: DEPTH-entry FIFO with a registered first-word-fall-through head (no bypass).
module mmio_wbuf_fifo
  import yavne_mmio_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  entry_t        din,
  input  logic          ready,
  output logic          valid,
  output entry_t        dout,
  output logic [LW-1:0] level,
  output logic          full
);
  entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic pop, load;
  // level also counts the head register, so storage holds level - valid entries
  always_comb begin
    pop = valid && ready;
    load = (!valid || pop) && level > LW'(valid);
    full = level == LW'(DEPTH);
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      valid <= 1'b0;
      dout <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (load) rd_ptr <= rd_ptr + AW'(1);
      if (load) dout <= mem[rd_ptr];
      valid <= load || (valid && !pop);
      level <= level + LW'(push) - LW'(pop);
    end
  end
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/mmio_write_buffer.sv
// mmio_write_buffer: window-filtered CPU write queue feeding the VGA framebuffer port.
// Define MMIO_WBUF_PATTERN_EN to add the pattern_en port and the built-in address sweep generator.
module mmio_write_buffer
  import yavne_mmio_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter logic [MMIO_ADDR_W-1:0] WIN_BASE = VGA_WIN_BASE,
  parameter logic [MMIO_ADDR_W-1:0] WIN_LAST = VGA_WIN_LAST
) (
  input  logic                   clock,
  input  logic                   reset_n,
  mmio_write_buffer_if.slave     bus,
`ifdef MMIO_WBUF_PATTERN_EN
  input  logic                   pattern_en,
`endif
  input  logic                   overflow_clr,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);
  logic full, push, drop, cpu_wr;
  entry_t din, head;
  assign cpu_wr = bus.cpu_we && in_window(bus.cpu_addr, WIN_BASE, WIN_LAST);
`ifdef MMIO_WBUF_PATTERN_EN
  logic [MMIO_ADDR_W-1:0] pat_addr;
  // the generator owns the queue while enabled and stalls rather than dropping
  always_comb begin
    din = pattern_en ? {pat_addr, 7'b0, pat_addr[0] ^ pat_addr[5]} : {bus.cpu_addr, bus.cpu_data};
    push = pattern_en ? !full : cpu_wr && !full;
    drop = !pattern_en && cpu_wr && full;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) pat_addr <= WIN_BASE;
    else if (pattern_en && !full) pat_addr <= pat_addr == WIN_LAST ? WIN_BASE : pat_addr + 16'd1;
  end
`else
  always_comb begin
    din = {bus.cpu_addr, bus.cpu_data};
    push = cpu_wr && !full;
    drop = cpu_wr && full;
  end
`endif
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) overflow <= 1'b0;
    else overflow <= drop || (overflow && !overflow_clr);
  end
  mmio_wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock(clock),
    .reset_n(reset_n),
    .push(push),
    .din(din),
    .ready(bus.out_ready),
    .valid(bus.out_valid),
    .dout(head),
    .level(level),
    .full(full)
  );
  assign bus.out_addr = head.addr;
  assign bus.out_data = head.data;
endmodule

// File: tb/tb_mmio_write_buffer.sv
// tb_mmio_write_buffer: randomized bench against a queue model of the window-filtered FWFT buffer.
module tb_mmio_write_buffer;
  import yavne_mmio_pkg::*;
  localparam int DEPTH = 16;
  logic clock = 0, reset_n = 0, overflow_clr = 0, overflow;
  logic [4:0] level;
`ifdef MMIO_WBUF_PATTERN_EN
  logic pattern_en = 0;
`endif
  mmio_write_buffer_if bus();
  mmio_write_buffer #(.DEPTH(DEPTH)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus),
`ifdef MMIO_WBUF_PATTERN_EN
    .pattern_en(pattern_en),
`endif
    .overflow_clr(overflow_clr),
    .level(level),
    .overflow(overflow)
  );
  always #5 clock = ~clock;

  typedef struct {logic [15:0] a; logic [7:0] d; int e;} ment_t;
  typedef struct {logic [15:0] a; logic [7:0] d;} pair_t;
  ment_t q[$];
  pair_t got[$];
  int cyc = 0, nvec = 0, nfail = 0;
  logic mov = 0;
  logic [15:0] mpat = 16'h0200;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, want %0h", n, act, exp);
    end
  endtask

  // an entry pushed at edge e becomes visible at the head no earlier than after edge e+1
  function automatic logic mvalid();
    return q.size() > 0 && q[0].e <= cyc - 1;
  endfunction

  task automatic check_model();
    chk("out_valid", {31'b0, bus.out_valid}, {31'b0, mvalid()});
    chk("level", {27'b0, level}, q.size());
    chk("overflow", {31'b0, overflow}, {31'b0, mov});
    if (mvalid()) begin
      chk("out_addr", {16'b0, bus.out_addr}, {16'b0, q[0].a});
      chk("out_data", {24'b0, bus.out_data}, {24'b0, q[0].d});
    end
  endtask

  task automatic cycle();
    logic pop, full, win, pat, psh, drp;
    logic [15:0] a;
    logic [7:0] d;
    full = q.size() == DEPTH;
    pop = mvalid() && bus.out_ready;
    win = bus.cpu_we && bus.cpu_addr >= 16'h0200 && bus.cpu_addr <= 16'h05FF;
    pat = 1'b0;
`ifdef MMIO_WBUF_PATTERN_EN
    pat = pattern_en;
`endif
    a = bus.cpu_addr;
    d = bus.cpu_data;
    psh = win && !full;
    drp = win && full;
    if (pat) begin
      a = mpat;
      d = {7'b0, mpat[0] ^ mpat[5]};
      psh = !full;
      drp = 1'b0;
    end
    if (bus.out_valid && bus.out_ready) got.push_back('{bus.out_addr, bus.out_data});
    @(posedge clock);
    if (reset_n) begin
      cyc++;
      if (pop) void'(q.pop_front());
      if (psh) q.push_back('{a, d, cyc});
      if (pat && psh) mpat = mpat == 16'h05FF ? 16'h0200 : mpat + 16'd1;
      mov = drp ? 1'b1 : overflow_clr ? 1'b0 : mov;
    end
    @(negedge clock);
    if (reset_n) check_model();
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus.cpu_we = 1;
    bus.cpu_addr = a;
    bus.cpu_data = d;
    cycle();
    bus.cpu_we = 0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    q.delete();
    mov = 0;
    mpat = 16'h0200;
    cycle();
    reset_n = 1;
  endtask

  initial begin
    logic [7:0] dv [4];
    int nw, budget;
    bus.cpu_we = 0;
    bus.cpu_addr = 0;
    bus.cpu_data = 0;
    bus.out_ready = 0;
    do_reset();
    chk("rst_valid", {31'b0, bus.out_valid}, 0);
    chk("rst_level", {27'b0, level}, 0);
    chk("rst_addr", {16'b0, bus.out_addr}, 0);
    check_model();
    // window edges: only 0x0200 and 0x05FF survive
    bus.out_ready = 1;
    got.delete();
    for (int i = 0; i < 4; i++) dv[i] = 8'($urandom);
    wr(16'h01FF, dv[0] ^ 8'h5A);
    wr(16'h0200, dv[0]);
    wr(16'h05FF, dv[2]);
    wr(16'h0600, dv[3]);
    repeat (4) cycle();
    chk("win_count", got.size(), 2);
    chk("win_0", {8'b0, got[0].a, got[0].d}, {8'b0, 16'h0200, dv[0]});
    chk("win_1", {8'b0, got[1].a, got[1].d}, {8'b0, 16'h05FF, dv[2]});
    chk("win_ovf", {31'b0, overflow}, 0);
    // fill past DEPTH, then a write while full with a simultaneous pop
    bus.out_ready = 0;
    got.delete();
    for (int i = 0; i < 17; i++) wr(16'h0300 + 16'(i), 8'(i));
    cycle();
    chk("fill_level", {27'b0, level}, 16);
    chk("fill_ovf", {31'b0, overflow}, 1);
    bus.out_ready = 1;
    wr(16'h0400, 8'hEE);
    bus.out_ready = 0;
    chk("fullpop_level", {27'b0, level}, 15);
    chk("fullpop_ovf", {31'b0, overflow}, 1);
    overflow_clr = 1;
    cycle();
    overflow_clr = 0;
    chk("ovf_clr", {31'b0, overflow}, 0);
    bus.out_ready = 1;
    repeat (20) cycle();
    chk("drain_count", got.size(), 16);
    for (int i = 0; i < 16; i++)
      chk($sformatf("drain_%0d", i), {8'b0, got[i].a, got[i].d}, {8'b0, 16'h0300 + 16'(i), 8'(i)});
    // clear and drop in the same cycle: drop wins
    bus.out_ready = 0;
    for (int i = 0; i < 16; i++) wr(16'h0500 + 16'(i), 8'(i));
    overflow_clr = 1;
    wr(16'h0520, 8'h77);
    overflow_clr = 0;
    chk("clr_vs_drop", {31'b0, overflow}, 1);
    bus.out_ready = 1;
    repeat (20) cycle();
    // randomized backpressure
    nw = 0;
    budget = 0;
    while (nw < 200 && budget < 5000) begin
      int r;
      budget++;
      bus.out_ready = 1'($urandom);
      overflow_clr = ($urandom % 16) == 0;
      r = $urandom % 4;
      if (r == 0) cycle();
      else if (r == 1) wr(($urandom % 2) ? 16'($urandom_range(0, 16'h01FF)) : 16'($urandom_range(16'h0600, 16'hFFFF)), 8'($urandom));
      else begin
        wr(16'($urandom_range(16'h0200, 16'h05FF)), 8'($urandom));
        nw++;
      end
    end
    chk("bp_writes", nw, 200);
    overflow_clr = 0;
    bus.out_ready = 1;
    repeat (DEPTH + 4) cycle();
    chk("bp_empty", {27'b0, level}, 0);
    // asynchronous reset mid-burst
    bus.out_ready = 0;
    for (int i = 0; i < 5; i++) wr(16'h0210 + 16'(i), 8'(i));
    cycle();
    chk("pre_rst_level", {27'b0, level}, 5);
    #2 reset_n = 0;
    #1;
    chk("async_valid", {31'b0, bus.out_valid}, 0);
    chk("async_level", {27'b0, level}, 0);
    chk("async_ovf", {31'b0, overflow}, 0);
    q.delete();
    mov = 0;
    mpat = 16'h0200;
    cycle();
    reset_n = 1;
    wr(16'h0250, 8'hA5);
    chk("post_rst_v0", {31'b0, bus.out_valid}, 0);
    chk("post_rst_lvl", {27'b0, level}, 1);
    cycle();
    chk("post_rst_v1", {31'b0, bus.out_valid}, 1);
    chk("post_rst_addr", {16'b0, bus.out_addr}, 32'h0250);
`ifdef MMIO_WBUF_PATTERN_EN
    do_reset();
    got.delete();
    bus.out_ready = 1;
    pattern_en = 1;
    for (int i = 0; i < 1030; i++) begin
      bus.out_ready = i < 100 ? 1'($urandom) : 1'b1;
      bus.cpu_we = 1'($urandom);
      bus.cpu_addr = 16'($urandom_range(16'h0200, 16'h05FF));
      cycle();
    end
    bus.cpu_we = 0;
    pattern_en = 0;
    repeat (DEPTH + 4) cycle();
    chk("pat_count", {31'b0, got.size() >= 1025}, 1);
    chk("pat_first", {16'b0, got[0].a}, 32'h0200);
    chk("pat_last", {16'b0, got[1023].a}, 32'h05FF);
    chk("pat_wrap", {16'b0, got[1024].a}, 32'h0200);
    chk("pat_d221", {24'b0, got[33].d}, 0);
    chk("pat_d201", {24'b0, got[1].d}, 1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
